// File: rtl/wu_decode_pkg.sv
// Shared definitions for the WU decode block: delineator and option encodings,
// the decoded-record layout, and the beat-merge helper.
package wu_decode_pkg;

  localparam int OPT_PER_INST = 3;
  localparam int OPT_TYPE_W   = 8;
  localparam int OPT_VALUE_W  = 16;
  localparam int OPT_TYPES_W  = OPT_PER_INST * OPT_TYPE_W;
  localparam int OPT_VALUES_W = OPT_PER_INST * OPT_VALUE_W;

  typedef enum logic [1:0] {
    CNTL_MOM     = 2'b00,
    CNTL_SOM     = 2'b01,
    CNTL_EOM     = 2'b10,
    CNTL_SOM_EOM = 2'b11
  } cntl_e;

  localparam logic [OPT_TYPE_W-1:0] OPT_NOP     = 8'd0;
  localparam logic [OPT_TYPE_W-1:0] OPT_OPCODE  = 8'd1;
  localparam logic [OPT_TYPE_W-1:0] OPT_ADDR_LO = 8'd2;
  localparam logic [OPT_TYPE_W-1:0] OPT_ADDR_HI = 8'd3;
  localparam logic [OPT_TYPE_W-1:0] OPT_TXFER   = 8'd4;
  localparam logic [OPT_TYPE_W-1:0] OPT_LANES   = 8'd5;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_IN_INST = 1'b1
  } state_e;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [31:0] addr;
    logic [15:0] txfer;
    logic [5:0]  lanes;
    logic [3:0]  desc_cnt;
    logic        err;
  } wud_rec_t;

  localparam int REC_W = $bits(wud_rec_t);

  // Folds one beat into a record; slots are walked upward so the higher slot wins.
  function automatic wud_rec_t merge_beat(wud_rec_t                base,
                                          logic [OPT_TYPES_W-1:0]  types,
                                          logic [OPT_VALUES_W-1:0] values,
                                          logic [1:0]              dcntl);
    wud_rec_t                r;
    logic [OPT_TYPE_W-1:0]   t;
    logic [OPT_VALUE_W-1:0]  v;
    r = base;
    for (int i = 0; i < OPT_PER_INST; i++) begin
      t = types[i*OPT_TYPE_W +: OPT_TYPE_W];
      v = values[i*OPT_VALUE_W +: OPT_VALUE_W];
      case (t)
        OPT_NOP:     ;
        OPT_OPCODE:  r.opcode     = v[7:0];
        OPT_ADDR_LO: r.addr[15:0]  = v;
        OPT_ADDR_HI: r.addr[31:16] = v;
        OPT_TXFER:   r.txfer      = v;
        OPT_LANES:   r.lanes      = v[5:0];
        default:     r.err        = 1'b1;
      endcase
    end
    if ((dcntl == CNTL_SOM || dcntl == CNTL_SOM_EOM) && r.desc_cnt != 4'hF)
      r.desc_cnt = r.desc_cnt + 4'd1;
    return r;
  endfunction

endpackage

// File: rtl/wu_decode_if.sv
// Beat bus from wu_memory and record bus to the dispatcher, as seen by wu_decode.
interface wu_decode_if;
  import wu_decode_pkg::*;

  logic                    wum__wud__valid;
  logic [1:0]              wum__wud__icntl;
  logic [1:0]              wum__wud__dcntl;
  logic [OPT_TYPES_W-1:0]  wum__wud__option_type;
  logic [OPT_VALUES_W-1:0] wum__wud__option_value;

  logic                    wud__dsp__valid;
  logic                    dsp__wud__ready;
  logic [7:0]              wud__dsp__opcode;
  logic [31:0]             wud__dsp__addr;
  logic [15:0]             wud__dsp__txfer;
  logic [5:0]              wud__dsp__lanes;
  logic [3:0]              wud__dsp__desc_cnt;
  logic                    wud__dsp__err;

  modport master (
    output wum__wud__valid, wum__wud__icntl, wum__wud__dcntl,
           wum__wud__option_type, wum__wud__option_value, dsp__wud__ready,
    input  wud__dsp__valid, wud__dsp__opcode, wud__dsp__addr, wud__dsp__txfer,
           wud__dsp__lanes, wud__dsp__desc_cnt, wud__dsp__err
  );

  modport slave (
    input  wum__wud__valid, wum__wud__icntl, wum__wud__dcntl,
           wum__wud__option_type, wum__wud__option_value, dsp__wud__ready,
    output wud__dsp__valid, wud__dsp__opcode, wud__dsp__addr, wud__dsp__txfer,
           wud__dsp__lanes, wud__dsp__desc_cnt, wud__dsp__err
  );
endinterface

// File: rtl/wu_decode_record_fifo.sv
// Generic first-word-fallthrough FIFO; a push into a full FIFO is dropped unless
// a pop happens in the same cycle.
module wud_record_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_next_o,
    output logic             drop_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             pop_ok, push_ok, full;

    assign valid_o      = (count_q != '0);
    assign full         = (count_q == CW'(DEPTH));
    assign pop_ok       = pop_i && valid_o;
    assign push_ok      = push_i && (!full || pop_ok);
    assign drop_o       = push_i && !push_ok;
    assign count_next_o = count_q + CW'(push_ok) - CW'(pop_ok);
    assign head_o       = mem_q[rd_ptr_q];

    // NOTE: storage has no reset; valid_o gates every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_next_o;
        end
    end

endmodule

// File: rtl/wu_decode.sv
// WU decode: assembles instruction beats from wu_memory into decoded records and
// queues them for the dispatcher, back-pressuring fetch when the queue runs low.
module wu_decode
    import wu_decode_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STALL_MARGIN = 2
) (
    input  logic        clk,
    input  logic        reset_poweron,
    wu_decode_if.slave  wud_if,
    output logic        xxx__wuf__stall,
    output logic [7:0]  wud__sys__proto_err_cnt,
    output logic        wud__sys__overflow
);

    localparam int CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int STALL_TH = FIFO_DEPTH - STALL_MARGIN;

    state_e   state_q, state_d;
    wud_rec_t acc_q, acc_d;
    logic     stall_q, stall_d;
    logic [7:0] perr_q, perr_d;
    logic     ovf_q, ovf_d;

    wud_rec_t fresh_rec, merged_rec, push_rec, head_rec;
    logic     push, proto_err;
    logic     fifo_valid, fifo_drop;
    logic [REC_W-1:0] fifo_head;
    logic [CW-1:0]    count_next;

    assign fresh_rec  = merge_beat('0, wud_if.wum__wud__option_type,
                                   wud_if.wum__wud__option_value, wud_if.wum__wud__dcntl);
    assign merged_rec = merge_beat(acc_q, wud_if.wum__wud__option_type,
                                   wud_if.wum__wud__option_value, wud_if.wum__wud__dcntl);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        push      = 1'b0;
        push_rec  = fresh_rec;
        proto_err = 1'b0;
        if (wud_if.wum__wud__valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    unique case (cntl_e'(wud_if.wum__wud__icntl))
                        CNTL_SOM: begin
                            acc_d   = fresh_rec;
                            state_d = ST_IN_INST;
                        end
                        CNTL_SOM_EOM: push = 1'b1;
                        default:      proto_err = 1'b1;
                    endcase
                end
                ST_IN_INST: begin
                    unique case (cntl_e'(wud_if.wum__wud__icntl))
                        CNTL_MOM: acc_d = merged_rec;
                        CNTL_EOM: begin
                            push     = 1'b1;
                            push_rec = merged_rec;
                            acc_d    = '0;
                            state_d  = ST_IDLE;
                        end
                        CNTL_SOM: begin
                            proto_err = 1'b1;
                            acc_d     = fresh_rec;
                        end
                        default: begin
                            proto_err = 1'b1;
                            push      = 1'b1;
                            acc_d     = '0;
                            state_d   = ST_IDLE;
                        end
                    endcase
                end
                default: state_d = ST_IDLE;
            endcase
        end
        stall_d = (count_next >= CW'(STALL_TH));
        perr_d  = (proto_err && perr_q != 8'hFF) ? perr_q + 8'd1 : perr_q;
        ovf_d   = ovf_q | fifo_drop;
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            stall_q <= 1'b0;
            perr_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            stall_q <= stall_d;
            perr_q  <= perr_d;
            ovf_q   <= ovf_d;
        end
    end

    wud_record_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (reset_poweron),
        .push_i       (push),
        .push_data_i  (push_rec),
        .pop_i        (wud_if.dsp__wud__ready),
        .valid_o      (fifo_valid),
        .head_o       (fifo_head),
        .count_next_o (count_next),
        .drop_o       (fifo_drop)
    );

    // Record fields read as zero whenever nothing is queued, including during reset.
    assign head_rec = fifo_valid ? wud_rec_t'(fifo_head) : '0;

    assign wud_if.wud__dsp__valid    = fifo_valid;
    assign wud_if.wud__dsp__opcode   = head_rec.opcode;
    assign wud_if.wud__dsp__addr     = head_rec.addr;
    assign wud_if.wud__dsp__txfer    = head_rec.txfer;
    assign wud_if.wud__dsp__lanes    = head_rec.lanes;
    assign wud_if.wud__dsp__desc_cnt = head_rec.desc_cnt;
    assign wud_if.wud__dsp__err      = head_rec.err;

    assign xxx__wuf__stall         = stall_q;
    assign wud__sys__proto_err_cnt = perr_q;
    assign wud__sys__overflow      = ovf_q;

endmodule

// File: tb/tb_wu_decode.sv
// Scoreboard bench for wu_decode: a per-cycle instruction model queues expected
// records; a negedge monitor compares the FIFO head and status outputs.
module tb_wu_decode;
  import wu_decode_pkg::*;

  localparam int DEPTH    = 4;
  localparam int STALL_TH = 2;

  logic       clk = 1'b0;
  logic       reset_poweron = 1'b0;
  logic       stall, ovf;
  logic [7:0] perr;

  always #5 clk = ~clk;

  wu_decode_if bus ();

  wu_decode #(.FIFO_DEPTH(DEPTH), .STALL_MARGIN(2)) dut (
    .clk                     (clk),
    .reset_poweron           (reset_poweron),
    .wud_if                  (bus),
    .xxx__wuf__stall         (stall),
    .wud__sys__proto_err_cnt (perr),
    .wud__sys__overflow      (ovf)
  );

  typedef struct {
    logic [7:0]  opcode;
    logic [31:0] addr;
    logic [15:0] txfer;
    logic [5:0]  lanes;
    logic [3:0]  desc;
    logic        err;
  } exp_rec_t;

  exp_rec_t exp_q[$];
  int  cur_t[$], cur_v[$];
  int  cur_desc;
  bit  in_inst;
  int  occ, m_perr;
  bit  m_ovf, m_stall;
  int  pub_occ, pub_perr;
  bit  pub_stall, pub_ovf;
  bit  mon_en = 1'b0;
  int  n_checks = 0, n_fail = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit [23:0] t3(int a, int b, int c);
    return {8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic bit [47:0] v3(int a, int b, int c);
    return {16'(c), 16'(b), 16'(a)};
  endfunction

  // Record from the option pairs collected so far, in arrival order (later wins).
  function automatic exp_rec_t build();
    exp_rec_t r;
    r = '{default: '0};
    for (int i = 0; i < cur_t.size(); i++) begin
      case (cur_t[i])
        0: ;
        1: r.opcode      = 8'(cur_v[i]);
        2: r.addr[15:0]  = 16'(cur_v[i]);
        3: r.addr[31:16] = 16'(cur_v[i]);
        4: r.txfer       = 16'(cur_v[i]);
        5: r.lanes       = 6'(cur_v[i] % 64);
        default: r.err   = 1'b1;
      endcase
    end
    r.desc = 4'((cur_desc > 15) ? 15 : cur_desc);
    return r;
  endfunction

  // One clock cycle: publish model state for the monitor, drive a beat, advance the model.
  task automatic step(bit v, bit [1:0] ic, bit [1:0] dc, bit [23:0] ty, bit [47:0] va, bit rdy);
    bit       pop, do_push, ds;
    exp_rec_t r;
    @(posedge clk);
    #1;
    pub_occ = occ; pub_stall = m_stall; pub_ovf = m_ovf; pub_perr = m_perr;
    bus.wum__wud__valid        = v;
    bus.wum__wud__icntl        = ic;
    bus.wum__wud__dcntl        = dc;
    bus.wum__wud__option_type  = ty;
    bus.wum__wud__option_value = va;
    bus.dsp__wud__ready        = rdy;
    pop     = (occ > 0) && rdy;
    do_push = 1'b0;
    ds      = (dc == 2'b01) || (dc == 2'b11);
    if (v) begin
      if (!in_inst && (ic == 2'b00 || ic == 2'b10)) begin
        m_perr = (m_perr < 255) ? m_perr + 1 : 255;
      end else begin
        if (ic == 2'b01 || ic == 2'b11) begin
          if (in_inst) m_perr = (m_perr < 255) ? m_perr + 1 : 255;
          cur_t.delete(); cur_v.delete(); cur_desc = 0;
        end
        for (int i = 0; i < 3; i++) begin
          cur_t.push_back(int'(ty[i*8 +: 8]));
          cur_v.push_back(int'(va[i*16 +: 16]));
        end
        if (ds) cur_desc++;
        in_inst = (ic == 2'b00 || ic == 2'b01);
        if (!in_inst) begin
          r       = build();
          do_push = 1'b1;
        end
      end
    end
    if (do_push) begin
      if (occ < DEPTH || pop) begin
        exp_q.push_back(r);
        occ++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (pop) occ--;
    m_stall = (occ >= STALL_TH);
  endtask

  task automatic idle(int n, bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 2'b00, '0, '0, rdy);
  endtask

  task automatic model_clear();
    exp_q.delete(); cur_t.delete(); cur_v.delete();
    cur_desc = 0; in_inst = 0; occ = 0; m_perr = 0; m_ovf = 0; m_stall = 0;
    pub_occ = 0; pub_perr = 0; pub_stall = 0; pub_ovf = 0;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_valid"},    bus.wud__dsp__valid, 0);
    check({tag, "_opcode"},   bus.wud__dsp__opcode, 0);
    check({tag, "_addr"},     bus.wud__dsp__addr, 0);
    check({tag, "_txfer"},    bus.wud__dsp__txfer, 0);
    check({tag, "_lanes"},    bus.wud__dsp__lanes, 0);
    check({tag, "_desc_cnt"}, bus.wud__dsp__desc_cnt, 0);
    check({tag, "_err"},      bus.wud__dsp__err, 0);
    check({tag, "_stall"},    stall, 0);
    check({tag, "_perr"},     perr, 0);
    check({tag, "_overflow"}, ovf, 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("valid", bus.wud__dsp__valid, pub_occ != 0);
      check("stall", stall, pub_stall);
      check("overflow", ovf, pub_ovf);
      check("proto_err_cnt", perr, pub_perr);
      if (bus.wud__dsp__valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_record: valid=1 opcode=0x%0h, expected no record", bus.wud__dsp__opcode);
        end else begin
          check("opcode",   bus.wud__dsp__opcode,   exp_q[0].opcode);
          check("addr",     bus.wud__dsp__addr,     exp_q[0].addr);
          check("txfer",    bus.wud__dsp__txfer,    exp_q[0].txfer);
          check("lanes",    bus.wud__dsp__lanes,    exp_q[0].lanes);
          check("desc_cnt", bus.wud__dsp__desc_cnt, exp_q[0].desc);
          check("err",      bus.wud__dsp__err,      exp_q[0].err);
          if (bus.dsp__wud__ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    model_clear();
    bus.wum__wud__valid = 0; bus.wum__wud__icntl = 0; bus.wum__wud__dcntl = 0;
    bus.wum__wud__option_type = '0; bus.wum__wud__option_value = '0; bus.dsp__wud__ready = 0;
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    reset_poweron = 1'b1;
    mon_en = 1'b1;

    // Single SOM_EOM beat: OPCODE, TXFER, LANES.
    step(1, 2'b11, 2'b11, t3(1, 4, 5), v3('h12, 'h40, 'h20), 1);
    idle(2, 1);
    // Three-beat instruction building a 32-bit address.
    step(1, 2'b01, 2'b01, t3(2, 0, 0), v3('hBEEF, 0, 0), 1);
    step(1, 2'b00, 2'b10, t3(3, 1, 0), v3('hDEAD, 3, 0), 1);
    step(1, 2'b10, 2'b11, t3(4, 0, 0), v3('h0100, 0, 0), 1);
    idle(2, 1);
    // Back-pressure: five records with ready low; the fifth is dropped.
    for (int i = 0; i < 5; i++) step(1, 2'b11, 2'b00, t3(1, 0, 0), v3(i + 'h20, 0, 0), 0);
    idle(2, 0);
    idle(6, 1);
    // Protocol errors: MOM while idle, then SOM restarting a partial instruction.
    step(1, 2'b00, 2'b00, t3(1, 0, 0), v3('h55, 0, 0), 1);
    step(1, 2'b01, 2'b01, t3(1, 0, 0), v3('h66, 0, 0), 1);
    step(1, 2'b01, 2'b01, t3(4, 0, 0), v3('h77, 0, 0), 1);
    idle(2, 1);
    step(1, 2'b10, 2'b00, t3(5, 0, 0), v3('h3F, 0, 0), 1);
    idle(2, 1);
    // Unknown type 0x09 plus duplicates within and across beats.
    step(1, 2'b01, 2'b00, t3(1, 9, 1), v3('hA1, 'h1234, 'hA2), 1);
    step(1, 2'b10, 2'b00, t3(4, 1, 0), v3('h0800, 'hA3, 0), 1);
    // SOM_EOM abandoning a partial instruction.
    step(1, 2'b01, 2'b01, t3(2, 0, 0), v3('h1111, 0, 0), 1);
    step(1, 2'b11, 2'b01, t3(3, 0, 0), v3('h2222, 0, 0), 1);
    idle(2, 1);
    // Descriptor count saturates at 15.
    step(1, 2'b01, 2'b01, t3(1, 0, 0), v3('hD0, 0, 0), 1);
    for (int i = 0; i < 17; i++) step(1, 2'b00, 2'b11, '0, '0, 1);
    step(1, 2'b10, 2'b01, '0, '0, 1);
    idle(2, 1);
    // Reset mid-instruction with two records queued.
    step(1, 2'b11, 2'b00, t3(1, 0, 0), v3('hC1, 0, 0), 0);
    step(1, 2'b11, 2'b00, t3(1, 0, 0), v3('hC2, 0, 0), 0);
    step(1, 2'b01, 2'b00, t3(1, 0, 0), v3('hC3, 0, 0), 0);
    @(posedge clk); #2;
    mon_en = 1'b0;
    reset_poweron = 1'b0;
    bus.wum__wud__valid = 0;
    #1;
    check_all_zero("async_reset");
    model_clear();
    @(posedge clk); #1;
    reset_poweron = 1'b1;
    mon_en = 1'b1;
    step(1, 2'b10, 2'b00, t3(1, 0, 0), v3('hEE, 0, 0), 1);
    idle(2, 1);
    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 2'($urandom), 2'($urandom),
           t3($urandom_range(0, 9), $urandom_range(0, 6), $urandom_range(0, 6)),
           v3($urandom, $urandom, $urandom), $urandom_range(0, 2) != 0);
    // proto_err_cnt saturates at 255.
    for (int i = 0; i < 260; i++) step(1, 2'b10, 2'b00, '0, '0, 1);
    for (int i = 0; i < 20 && occ > 0; i++) idle(1, 1);
    idle(2, 1);
    check("scoreboard_drained", exp_q.size(), 0);
    check("proto_err_saturated", perr, 255);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wu_decode.md
Name: wu_decode

Overview:
- Receiving end of the WU memory → WU decode interface inside the manager.
- Consumes instruction beats from wu_memory: each beat carries instruction/descriptor delineators and MGR_WU_OPT_PER_INST option type/value pairs.
- Assembles each instruction into one decoded record and buffers records in a small FIFO for the downstream dispatcher.
- Back-pressures wu_fetch/wu_memory through xxx__wuf__stall.

Parameters:
- OPT_PER_INST, 3, option slots per beat
- OPT_TYPE_W, 8, option type width
- OPT_VALUE_W, 16, option value width
- FIFO_DEPTH, 4, decoded-record FIFO entries (power of 2)
- STALL_MARGIN, 2, free entries that must remain when stall asserts; covers fetch/memory read latency

Ports:
- clk  in  1  clock
- reset_poweron  in  1  asynchronous, active-low reset
- wum__wud__valid  in  1  beat valid; no ready, beats are accepted unconditionally
- wum__wud__icntl  in  2  instruction delineator
- wum__wud__dcntl  in  2  descriptor delineator
- wum__wud__option_type  in  OPT_PER_INST*OPT_TYPE_W  packed; slot i at [i*W +: W]
- wum__wud__option_value  in  OPT_PER_INST*OPT_VALUE_W  packed, same layout
- xxx__wuf__stall  out  1  registered back-pressure to fetch
- wud__dsp__valid  out  1  record available (FIFO head)
- dsp__wud__ready  in  1  downstream accepts head
- wud__dsp__opcode  out  8  opcode
- wud__dsp__addr  out  32  {ADDR_HI, ADDR_LO}
- wud__dsp__txfer  out  16  transfer size
- wud__dsp__lanes  out  6  lane count
- wud__dsp__desc_cnt  out  4  descriptors in instruction, saturating at 15
- wud__dsp__err  out  1  unknown option type seen in instruction
- wud__sys__proto_err_cnt  out  8  saturating protocol-error counter
- wud__sys__overflow  out  1  sticky; record dropped on full FIFO

Behaviour:
- Delineator encoding (both cntl fields): 2'b00 MOM, 2'b01 SOM, 2'b10 EOM, 2'b11 SOM_EOM.
- Reset (async assert, sync deassert handled at top):
  - All outputs 0; FIFO empty; state IDLE; accumulator cleared.
  - Reset mid-instruction discards the partial record.
- Option types:
  - 0 NOP: ignored.
  - 1 OPCODE: value[7:0].
  - 2 ADDR_LO, 3 ADDR_HI.
  - 4 TXFER.
  - 5 LANES: value[5:0].
  - Any other type sets the accumulator err bit.
  - Duplicate type within an instruction: last wins. Within one beat, the higher slot index wins.
- Descriptor count: +1 per valid beat whose dcntl is SOM or SOM_EOM.
- State machine:
  - IDLE
    - icntl SOM → load accumulator with this beat's fields → IN_INST.
    - icntl SOM_EOM → push the merged record → stay IDLE.
    - MOM/EOM → drop beat, proto_err_cnt+1.
  - IN_INST
    - MOM → merge beat.
    - EOM → push merged record (accumulator + this beat) → IDLE.
    - SOM → abandon partial, proto_err_cnt+1, restart accumulator with this beat.
    - SOM_EOM → abandon partial, proto_err_cnt+1, push this beat's record alone, → IDLE.
- Fields absent from an instruction are 0 in the record.
- Latency: EOM beat in cycle N → record written at the edge ending N → wud__dsp__valid high in N+1 if FIFO was empty. Head is first-word-fallthrough.
- Pop occurs when wud__dsp__valid && dsp__wud__ready.
- Push to full FIFO without a same-cycle pop: record dropped, wud__sys__overflow set (sticky until reset).
- Push + pop in the same cycle on a full FIFO: both succeed, count unchanged.
- Push + pop in the same cycle on an empty FIFO: the new record is not visible until N+1; no pop occurs.
- xxx__wuf__stall:
  - Registered: next value = (count_next >= FIFO_DEPTH - STALL_MARGIN).
  - Deasserts the cycle after count drops below the threshold.
- Pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.
- proto_err_cnt saturates at 255.

Decomposition:
- Shared package (manager.vh / common.vh): cntl encodings (SOM/MOM/EOM/SOM_EOM), option type codes, the record field ranges, and the MGR_WU_OPT_* widths.
- Sub-module wud_record_fifo: generic synchronous FWFT FIFO (width, depth parameters) with count output.
- Decode FSM and accumulator stay in wu_decode.

Test Plan:
- Single SOM_EOM beat {OPCODE=0x12, TXFER=0x0040, LANES=0x20} → next cycle valid=1, opcode=0x12, txfer=0x0040, lanes=32, addr=0, desc_cnt=1, err=0.
- SOM {ADDR_LO=0xBEEF}, MOM {ADDR_HI=0xDEAD, OPCODE=0x03}, EOM {TXFER=0x0100}, dcntl SOM/EOM/SOM_EOM → one record: addr=0xDEADBEEF, opcode=0x03, txfer=0x0100, desc_cnt=2.
- Hold ready=0 and send 5 single-beat instructions → stall registered high once count reaches 2; the 5th record is dropped and overflow=1; release ready → 4 records drain in order.
- MOM beat while IDLE, then SOM, SOM → proto_err_cnt=2; no record emitted until the following EOM.
- Beat with type 0x09 inside an instruction → record err=1; other fields decoded normally.
- Assert reset mid-instruction with 2 records queued → all outputs 0 asynchronously; after release, an EOM beat counts as a protocol error.
